// File: rtl/alu_result_demux_if.sv
// rtl/alu_result_demux_if.sv - producer and consumer signal bundle for alu_result_demux
interface alu_result_demux_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           ALUcontrol;
    logic [WIDTH-1:0]     in_data;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic [WIDTH-1:0]     d;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [4*CNT_W-1:0]   xfer_cnt;

    // Environment side: drives the producer stream and the consumer readies.
    modport master (
        output in_valid, ALUcontrol, in_data, out_ready,
        input  in_ready, a, b, c, d, out_valid, xfer_cnt
    );

    // Demux side.
    modport slave (
        input  in_valid, ALUcontrol, in_data, out_ready,
        output in_ready, a, b, c, d, out_valid, xfer_cnt
    );
endinterface

// File: rtl/alu_result_demux.sv
// rtl/alu_result_demux.sv - registered 1-to-4 result demux; ALU_RESULT_DEMUX_ZERO_IDLE_EN zeroes idle output buses
module alu_result_demux #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    alu_result_demux_if.slave bus
);

    logic [WIDTH-1:0] hold [4];
    logic [3:0]       vld;
    logic [CNT_W-1:0] cnt  [4];
    logic             accept;
    logic [3:0]       load;

    // A channel can take a word if it is empty or being drained this same cycle.
    assign bus.in_ready = !vld[bus.ALUcontrol] | bus.out_ready[bus.ALUcontrol];
    assign accept       = bus.in_valid & bus.in_ready;

    // One-hot load strobe for the addressed channel; only one channel loads per cycle.
    always_comb begin
        load = 4'b0000;
        if (accept) begin
            load = 4'b0001 << bus.ALUcontrol;
        end
    end

    // Holding registers, valid flags and accept counters; load wins over drain so a
    // drained-and-refilled channel stays valid with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                hold[i] <= '0;
                cnt[i]  <= '0;
            end
            vld <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    hold[i] <= bus.in_data;
                    vld[i]  <= 1'b1;
                    cnt[i]  <= cnt[i] + CNT_W'(1);
                end else if (bus.out_ready[i]) begin
                    vld[i]  <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = vld;

    // Counter vector: channel i occupies bits [i*CNT_W +: CNT_W].
    assign bus.xfer_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};

`ifdef ALU_RESULT_DEMUX_ZERO_IDLE_EN
    // Idle channels present zeros; the held words are untouched underneath.
    assign bus.a = vld[0] ? hold[0] : '0;
    assign bus.b = vld[1] ? hold[1] : '0;
    assign bus.c = vld[2] ? hold[2] : '0;
    assign bus.d = vld[3] ? hold[3] : '0;
`else
    // Output buses always show the last loaded word.
    assign bus.a = hold[0];
    assign bus.b = hold[1];
    assign bus.c = hold[2];
    assign bus.d = hold[3];
`endif

endmodule

// File: tb/tb_alu_result_demux.sv
// tb/tb_alu_result_demux.sv - directed self-checking bench for alu_result_demux
module tb_alu_result_demux;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   stall_cycles;

    alu_result_demux_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_result_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return bus.xfer_cnt[ch*CNT_W +: CNT_W];
    endfunction

    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] data, input logic [3:0] rdy);
        bus.in_valid   = v;
        bus.ALUcontrol = sel;
        bus.in_data    = data;
        bus.out_ready  = rdy;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 4'b0000);
        #2;
        check("reset_valid", 64'(bus.out_valid), 64'h0);
        check("reset_a", 64'(bus.a), 64'h0);
        check("reset_d", 64'(bus.d), 64'h0);
        check("reset_cnt", 64'(bus.xfer_cnt), 64'h0);
        tick();
        rst = 1'b0;

        // First word to channel c.
        drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
        #1;
        check("c_in_ready", 64'(bus.in_ready), 64'h1);
        tick();
        drive(1'b0, 2'd0, 32'h0, 4'b0000);
        check("c_data", 64'(bus.c), 64'hDEADBEEF);
        check("c_valid", 64'(bus.out_valid), 64'h4);
        check("c_cnt", 64'(cnt_of(2)), 64'h1);
        check("c_a_b_d_zero", 64'(bus.a | bus.b | bus.d), 64'h0);

        // Load b while draining c in the same cycle.
        drive(1'b1, 2'd1, 32'h00001111, 4'b0100);
        tick();
        check("b_load_c_drain", 64'(bus.out_valid), 64'h2);
        // b full and stalled: its words are refused, b holds.
        drive(1'b1, 2'd1, 32'h00002222, 4'b0000);
        #1;
        check("b_stall_ready", 64'(bus.in_ready), 64'h0);
        tick();
        check("b_stall_data", 64'(bus.b), 64'h00001111);
        check("b_stall_cnt", 64'(cnt_of(1)), 64'h1);
        // A word for d is not blocked by stalled b.
        drive(1'b1, 2'd3, 32'h00000005, 4'b0000);
        #1;
        check("d_ready_past_b", 64'(bus.in_ready), 64'h1);
        tick();
        drive(1'b0, 2'd0, 32'h0, 4'b0000);
        check("d_data", 64'(bus.d), 64'h5);
        check("b_d_valid", 64'(bus.out_valid), 64'hA);

        // Drain b and d with nothing arriving; out_ready on empty a has no effect.
        drive(1'b0, 2'd0, 32'h0, 4'b1011);
        tick();
        check("drain_valid", 64'(bus.out_valid), 64'h0);
`ifdef ALU_RESULT_DEMUX_ZERO_IDLE_EN
        check("drain_b_bus", 64'(bus.b), 64'h0);
`else
        check("drain_b_bus", 64'(bus.b), 64'h00001111);
`endif

        // Fill a, then drain and refill it in the same cycle.
        drive(1'b1, 2'd0, 32'h0000AAAA, 4'b0000);
        tick();
        check("a_first", 64'(bus.a), 64'h0000AAAA);
        drive(1'b1, 2'd0, 32'h00001234, 4'b0001);
        #1;
        check("a_refill_ready", 64'(bus.in_ready), 64'h1);
        tick();
        drive(1'b0, 2'd0, 32'h0, 4'b0000);
        check("a_refill_data", 64'(bus.a), 64'h00001234);
        check("a_refill_valid", 64'(bus.out_valid), 64'h1);
        check("a_refill_cnt", 64'(cnt_of(0)), 64'h2);

        // Back-to-back to d with its consumer always ready; d count starts at 1.
        stall_cycles = 0;
        for (int i = 0; i < 254; i++) begin
            drive(1'b1, 2'd3, 32'(i), 4'b1000);
            #1;
            if (bus.in_ready !== 1'b1) stall_cycles++;
            tick();
        end
        check("d_cnt_255", 64'(cnt_of(3)), 64'hFF);
        drive(1'b1, 2'd3, 32'h0000BEEF, 4'b1000);
        #1;
        if (bus.in_ready !== 1'b1) stall_cycles++;
        tick();
        drive(1'b0, 2'd0, 32'h0, 4'b0000);
        check("d_stream_stalls", 64'(stall_cycles), 64'h0);
        check("d_cnt_wrap", 64'(cnt_of(3)), 64'h0);
        check("d_last_data", 64'(bus.d), 64'h0000BEEF);
        check("d_stream_valid", 64'(bus.out_valid), 64'h9);

        // Fill b and c, so all four hold words, then reset between edges.
        drive(1'b1, 2'd1, 32'h0000B0B0, 4'b0000);
        tick();
        drive(1'b1, 2'd2, 32'h0000C0C0, 4'b0000);
        tick();
        drive(1'b0, 2'd0, 32'h0, 4'b0000);
        check("all_full", 64'(bus.out_valid), 64'hF);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 64'(bus.out_valid), 64'h0);
        check("async_data", 64'(bus.a | bus.b | bus.c | bus.d), 64'h0);
        check("async_cnt", 64'(bus.xfer_cnt), 64'h0);
        tick();
        rst = 1'b0;
        drive(1'b1, 2'd0, 32'h00000077, 4'b0000);
        tick();
        check("post_rst_a", 64'(bus.a), 64'h77);
        check("post_rst_cnt", 64'(bus.xfer_cnt), 64'h1);
        check("post_rst_valid", 64'(bus.out_valid), 64'h1);

        // Idle-bus behaviour after draining a.
        drive(1'b1, 2'd0, 32'hFFFF0000, 4'b0001);
        tick();
        check("a_ffff", 64'(bus.a), 64'hFFFF0000);
        drive(1'b0, 2'd0, 32'h0, 4'b0001);
        tick();
        drive(1'b0, 2'd0, 32'h0, 4'b0000);
        check("a_idle_valid", 64'(bus.out_valid), 64'h0);
`ifdef ALU_RESULT_DEMUX_ZERO_IDLE_EN
        check("a_idle_bus", 64'(bus.a), 64'h0);
`else
        check("a_idle_bus", 64'(bus.a), 64'hFFFF0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_result_demux.md
Name: alu_result_demux

Overview:
- Registered 1-to-4 demultiplexer: the distributing counterpart of the 4:1 ALU result select.
- One producer stream carries a 32-bit word and a 2-bit ALUcontrol tag.
- The word is steered into one of four output holding registers (a, b, c, d), each with its own valid/ready handshake toward its consumer.
- Per-channel transfer counters give the debug/status view.

Parameters:
- WIDTH, 32, data width of input and each output channel.
- CNT_W, 8, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block accepts the word this cycle.
- ALUcontrol  input  2  destination select: 0→a, 1→b, 2→c, 3→d.
- in_data  input  WIDTH  word to route.
- a, b, c, d  output  WIDTH each  channel holding-register contents.
- out_valid  output  4  bit i = channel i holds a word (bit0=a … bit3=d).
- out_ready  input  4  bit i = consumer i takes the word this cycle.
- xfer_cnt  output  4*CNT_W  accepted-word counter per channel; channel i at bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (async, rst=1): a, b, c, d = 0; out_valid = 0; xfer_cnt = 0. The held state is cleared immediately, without waiting for a clock edge.
- in_ready is combinational: in_ready = !out_valid[ALUcontrol] | out_ready[ALUcontrol]. A channel that is being drained this cycle accepts a new word in the same cycle.
- in_ready depends only on the selected channel. A stalled channel does not block words tagged for other channels.
- Accept event: in_valid & in_ready. On the clock edge, channel sel = ALUcontrol loads in_data and sets out_valid[sel]=1.
- Latency: the word is visible on its channel one cycle after acceptance. There is no combinational path from in_data to the outputs.
- Drain event on channel i: out_valid[i] & out_ready[i].
  - Without a simultaneous load to i: out_valid[i] clears on the edge.
  - With a simultaneous load to i: the data is replaced, out_valid[i] stays 1 and there is no bubble.
- Channel register contents change only on a load (base build). out_ready[i] asserted while out_valid[i]=0 has no effect.
- At most one channel loads per cycle. Any number of channels may drain in the same cycle.
- xfer_cnt[i] increments by 1 on each accept to channel i and wraps modulo 2^CNT_W (255→0 for CNT_W=8). Drains do not affect it.
- in_valid=0: no state change except drains. ALUcontrol and in_data are don't-care when in_valid=0.
- Producer rule: in_data and ALUcontrol stay stable while in_valid=1 and in_ready=0. The block does not check this.
- Reset asserted mid-transfer: any held words are discarded and counters are cleared. After rst falls, the first accepted word behaves exactly as from power-up.

Optional Feature:
- Macro: ALU_RESULT_DEMUX_ZERO_IDLE_EN.
- Defined: output bus i is gated to 0 whenever out_valid[i]=0, so consumers see zeros on idle channels. The registers themselves are unchanged.
- Undefined: output bus i shows the last loaded value (0 after reset) regardless of out_valid[i].
- Handshake, latency and counters are identical in both builds.

Test Plan:
- Reset, then in_valid=1, ALUcontrol=2, in_data=0xDEADBEEF, out_ready=0 → in_ready=1; next cycle c=0xDEADBEEF, out_valid=4'b0100, xfer_cnt for c =1; a/b/d unchanged.
- Channel b holds a word, out_ready[1]=0, present ALUcontrol=1 → in_ready=0, b unchanged; switch to ALUcontrol=3, data 0x5 → accepted, d=0x5, out_valid=4'b1010.
- Channel a full, out_ready[0]=1 with simultaneous accept of 0x1234 to a → next cycle a=0x1234, out_valid[0] remains 1, xfer_cnt for a increments once.
- 256 back-to-back accepts to channel d with out_ready[3]=1 (CNT_W=8) → xfer_cnt for d wraps to 0; in_ready held at 1 every cycle.
- Load all four channels, assert rst asynchronously between clock edges → out_valid=0, a..d=0, xfer_cnt=0 before the next edge.
- With ALU_RESULT_DEMUX_ZERO_IDLE_EN defined: load a=0xFFFF0000, drain it → a reads 0 the cycle after the drain. Without the macro: a still reads 0xFFFF0000.
